// File: rtl/vector_scoreboard_mc_if.sv
// Issue/completion bundle between the scalar front end and vector_scoreboard_mc.
// master: issue-side driver (FIFO, vector unit, completion sources); slave: the scoreboard.
interface vector_scoreboard_mc_if #(
  parameter int unsigned DATA_FROM_SCALAR = 96,
  parameter int unsigned REGISTER_NUMBERS = 32,
  parameter int unsigned ALU_CHANNELS     = 2
);
  localparam int unsigned RW = $clog2(REGISTER_NUMBERS);

  logic                               valid_fifo;
  logic [DATA_FROM_SCALAR-1:0]        instruction_to_issue;
  logic                               ready_vector;
  logic [ALU_CHANNELS-1:0]            alu_done;
  logic [ALU_CHANNELS-1:0][RW-1:0]    alu_dest;
  logic                               mem_done;
  logic [RW-1:0]                      mem_dest;
  logic                               valid_vector;
  logic [ALU_CHANNELS-1:0]            alu_sel;
  logic                               pop_data;
  logic                               busy;

  modport master (
    output valid_fifo, instruction_to_issue, ready_vector,
    output alu_done, alu_dest, mem_done, mem_dest,
    input  valid_vector, alu_sel, pop_data, busy
  );

  modport slave (
    input  valid_fifo, instruction_to_issue, ready_vector,
    input  alu_done, alu_dest, mem_done, mem_dest,
    output valid_vector, alu_sel, pop_data, busy
  );
endinterface

// File: rtl/vector_scoreboard_mc.sv
// Vector register scoreboard: per-register hazard status, multi-channel ALU and memory occupancy.
// Optional macro SCOREBOARD_MASK_CHECK_EN: masked instructions also wait on register v0.
module vector_scoreboard_mc #(
  parameter int unsigned INSTRUCTION_BITS = 32,
  parameter int unsigned REGISTER_NUMBERS = 32,
  parameter int unsigned DATA_FROM_SCALAR = 96,
  parameter int unsigned ALU_CHANNELS     = 2,
  parameter int unsigned MUL_CYCLES       = 4
) (
  input logic                 clk,
  input logic                 rst_n,
  vector_scoreboard_mc_if.slave bus
);
  localparam int unsigned RW = $clog2(REGISTER_NUMBERS);
  localparam int unsigned IW = $clog2(REGISTER_NUMBERS + 1);
  localparam int unsigned CW = (MUL_CYCLES > 2) ? $clog2(MUL_CYCLES - 1) : 1;

  typedef enum logic [1:0] {R_IDLE, R_LANE, R_LOAD, R_STORE} reg_state_e;
  typedef enum logic       {CH_FREE, CH_MUL}                 ch_state_e;
  typedef enum logic [1:0] {M_FREE, M_LOAD, M_STORE}         mem_state_e;

  reg_state_e status_q [REGISTER_NUMBERS];
  reg_state_e status_d [REGISTER_NUMBERS];
  ch_state_e  ch_q     [ALU_CHANNELS];
  ch_state_e  ch_d     [ALU_CHANNELS];
  logic [CW-1:0] cnt_q [ALU_CHANNELS];
  logic [CW-1:0] cnt_d [ALU_CHANNELS];
  mem_state_e mem_q, mem_d;

  logic [INSTRUCTION_BITS-1:0] instr;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [5:0]  funct6;
  logic        is_lane, is_load, is_store, is_vset, is_mul, masked, indexed;
  logic        chk_a, chk_b, mask_ok, lane_ok, mem_ok, issuable, accept;
  logic [IW-1:0] src_a_idx, src_b_idx, dest_idx;
  logic [RW-1:0] dest_r;
  logic [REGISTER_NUMBERS:0] avail;
  logic [ALU_CHANNELS-1:0]   first_free;
  logic                      any_free;
  logic                      vv, pop, busy_w;
  logic [ALU_CHANNELS-1:0]   sel;
  logic                      unused_low_bits;

  assign instr           = bus.instruction_to_issue[DATA_FROM_SCALAR-1 -: INSTRUCTION_BITS];
  assign unused_low_bits = ^bus.instruction_to_issue[DATA_FROM_SCALAR-INSTRUCTION_BITS-1:0];

  // Decode, operand availability (with same-cycle completion bypass) and issue conditions
  always_comb begin
    opcode   = instr[6:0];
    funct3   = instr[14:12];
    funct6   = instr[31:26];
    is_lane  = (opcode == 7'b1010111);
    is_load  = (opcode == 7'b0000111);
    is_store = (opcode == 7'b0100111);
    is_vset  = is_lane && (funct3 == 3'b111);
    masked   = !instr[25];
    indexed  = instr[26];
    is_mul   = is_lane && (funct3 inside {3'b010, 3'b110}) &&
               (funct6 inside {6'b100100, 6'b100101, 6'b100110, 6'b100111, 6'b101001, 6'b101101});
    chk_a    = is_lane && !(funct3 inside {3'b011, 3'b100, 3'b101, 3'b110});
    chk_b    = (is_lane && !((funct6 == 6'b010111) && (funct3 inside {3'b000, 3'b011, 3'b100}))) ||
               ((is_load || is_store) && indexed);
    // Unchecked operands point at the always-idle dummy entry past the last register
    src_a_idx = chk_a ? IW'(instr[19:15]) : IW'(REGISTER_NUMBERS);
    src_b_idx = chk_b ? IW'(instr[24:20]) : IW'(REGISTER_NUMBERS);
    dest_idx  = IW'(instr[11:7]);
    dest_r    = RW'(instr[11:7]);

    avail = '0;
    for (int unsigned r = 0; r < REGISTER_NUMBERS; r++) begin
      avail[r] = (status_q[r] == R_IDLE) || (bus.mem_done && (bus.mem_dest == RW'(r)));
      for (int unsigned i = 0; i < ALU_CHANNELS; i++) begin
        if (bus.alu_done[i] && (bus.alu_dest[i] == RW'(r))) avail[r] = 1'b1;
      end
    end
    avail[REGISTER_NUMBERS] = 1'b1;

    first_free = '0;
    any_free   = 1'b0;
    for (int unsigned i = 0; i < ALU_CHANNELS; i++) begin
      if ((ch_q[i] == CH_FREE) && !any_free) begin
        first_free[i] = 1'b1;
        any_free      = 1'b1;
      end
    end

`ifdef SCOREBOARD_MASK_CHECK_EN
    mask_ok = !masked || avail[0];
`else
    mask_ok = 1'b1;
`endif

    lane_ok  = is_lane && !is_vset && avail[src_a_idx] && avail[src_b_idx] &&
               avail[dest_idx] && any_free && mask_ok;
    mem_ok   = (is_load || is_store) && ((mem_q == M_FREE) || bus.mem_done) &&
               avail[dest_idx] && avail[src_b_idx] && mask_ok;
    issuable = lane_ok || mem_ok;
  end

  // Output process
  always_comb begin
    vv     = issuable && bus.valid_fifo;
    pop    = vv || (bus.valid_fifo && is_vset);
    sel    = (vv && is_lane) ? first_free : '0;
    busy_w = (mem_q != M_FREE);
    for (int unsigned r = 0; r < REGISTER_NUMBERS; r++) begin
      if (status_q[r] != R_IDLE) busy_w = 1'b1;
    end
    for (int unsigned i = 0; i < ALU_CHANNELS; i++) begin
      if (ch_q[i] == CH_MUL) busy_w = 1'b1;
    end
  end

  assign bus.valid_vector = vv;
  assign bus.pop_data     = pop;
  assign bus.alu_sel      = sel;
  assign bus.busy         = busy_w;

  // Next-state process: clears first so a same-register set overrides them
  always_comb begin
    accept   = vv && bus.ready_vector;
    status_d = status_q;
    ch_d     = ch_q;
    cnt_d    = cnt_q;
    mem_d    = mem_q;
    for (int unsigned i = 0; i < ALU_CHANNELS; i++) begin
      if (bus.alu_done[i]) status_d[bus.alu_dest[i]] = R_IDLE;
    end
    if (bus.mem_done) status_d[bus.mem_dest] = R_IDLE;
    if (accept) status_d[dest_r] = is_lane ? R_LANE : (is_load ? R_LOAD : R_STORE);

    if (accept && is_load)       mem_d = M_LOAD;
    else if (accept && is_store) mem_d = M_STORE;
    else if (bus.mem_done)       mem_d = M_FREE;

    for (int unsigned i = 0; i < ALU_CHANNELS; i++) begin
      if (ch_q[i] == CH_MUL) begin
        if (cnt_q[i] == '0) ch_d[i] = CH_FREE;
        else                cnt_d[i] = cnt_q[i] - 1'b1;
      end
      if (accept && is_mul && sel[i]) begin
        ch_d[i]  = CH_MUL;
        cnt_d[i] = CW'(MUL_CYCLES - 2);
      end
    end
  end

  // State register process
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned r = 0; r < REGISTER_NUMBERS; r++) status_q[r] <= R_IDLE;
      for (int unsigned i = 0; i < ALU_CHANNELS; i++) begin
        ch_q[i]  <= CH_FREE;
        cnt_q[i] <= '0;
      end
      mem_q <= M_FREE;
    end else begin
      status_q <= status_d;
      ch_q     <= ch_d;
      cnt_q    <= cnt_d;
      mem_q    <= mem_d;
    end
  end
endmodule
